// File: rtl/tt_um_taghreed_eialsalman_tdm_demux.sv
// Two-channel TDM demultiplexer.
// Serial samples arrive interleaved as A3 B3 A2 B2 A1 B1 A0 B0, MSB first.
// Each completed nibble is registered onto uo_out with a one-cycle valid pulse.
// A frame sync arriving mid-frame restarts the frame and raises a sticky error flag.
module tt_um_taghreed_eialsalman_tdm_demux (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic       w_d;
  logic       w_fs;
  logic       w_v;
  logic [2:0] w_eff_cnt;
  logic       w_fs_err;
  logic       w_unused;

  logic [2:0] r_cnt;
  logic [3:0] r_sh_a;
  logic [3:0] r_sh_b;
  logic [7:0] r_out;
  logic       r_a_vld;
  logic       r_b_vld;
  logic       r_sync_err;

  assign w_d      = ui_in[0];
  assign w_fs     = ui_in[1];
  assign w_v      = ui_in[2];
  assign w_unused = &{ena, uio_in, ui_in[7:3], 1'b0};

  // A frame sync forces the current sample to be treated as A3.
  assign w_eff_cnt = w_fs ? 3'd0 : r_cnt;
  assign w_fs_err  = w_v && w_fs && (r_cnt != 3'd0);

  // Sample counter and the sticky sync-error flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt      <= 3'd0;
      r_sync_err <= 1'b0;
    end else if (w_v) begin
      r_cnt <= w_eff_cnt + 3'd1;
      if (w_fs_err) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  // Channel shift registers; a frame sync starts both from a clean slate.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_a <= 4'd0;
      r_sh_b <= 4'd0;
    end else if (w_v) begin
      if (w_fs) begin
        r_sh_a <= {3'b000, w_d};
        r_sh_b <= 4'd0;
      end else if (!w_eff_cnt[0]) begin
        r_sh_a <= {r_sh_a[2:0], w_d};
      end else begin
        r_sh_b <= {r_sh_b[2:0], w_d};
      end
    end
  end

  // Output nibbles load on the last bit of each channel; valid strobes last one cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out   <= 8'h00;
      r_a_vld <= 1'b0;
      r_b_vld <= 1'b0;
    end else begin
      r_a_vld <= 1'b0;
      r_b_vld <= 1'b0;
      if (w_v && (w_eff_cnt == 3'd6)) begin
        r_out[3:0] <= {r_sh_a[2:0], w_d};
        r_a_vld    <= 1'b1;
      end
      if (w_v && (w_eff_cnt == 3'd7)) begin
        r_out[7:4] <= {r_sh_b[2:0], w_d};
        r_b_vld    <= 1'b1;
      end
    end
  end

  assign uo_out  = r_out;
  assign uio_out = {4'b0000, r_cnt[0], r_sync_err, r_b_vld, r_a_vld};
  assign uio_oe  = 8'b0000_1111;

endmodule

// File: tb/tb_tt_um_taghreed_eialsalman_tdm_demux.sv
// Bench for the TDM demultiplexer: directed frames plus random traffic,
// all checked every cycle against a frame-position model.
module tb_tt_um_taghreed_eialsalman_tdm_demux;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_cmp;
  int n_bad;

  tt_um_taghreed_eialsalman_tdm_demux dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within frame plus accumulated channel values.
  int         pos;
  int         acc_a;
  int         acc_b;
  logic [7:0] m_out;
  logic       m_avld;
  logic       m_bvld;
  logic       m_err;
  bit         started;

  initial begin
    pos = 0; acc_a = 0; acc_b = 0; m_out = 8'h00;
    m_avld = 1'b0; m_bvld = 1'b0; m_err = 1'b0; started = 1'b0;
  end

  always @(posedge clk) begin
    int d;
    d = int'(ui_in[0]);
    m_avld = 1'b0;
    m_bvld = 1'b0;
    if (!rst_n) begin
      pos = 0; acc_a = 0; acc_b = 0; m_out = 8'h00; m_err = 1'b0;
    end else if (ui_in[2]) begin
      if (ui_in[1]) begin
        if (pos != 0) m_err = 1'b1;
        pos = 0; acc_a = 0; acc_b = 0;
      end
      if (pos % 2 == 0) acc_a = (acc_a * 2 + d) % 16;
      else              acc_b = (acc_b * 2 + d) % 16;
      if (pos == 6) begin m_out[3:0] = acc_a[3:0]; m_avld = 1'b1; end
      if (pos == 7) begin m_out[7:4] = acc_b[3:0]; m_bvld = 1'b1; end
      pos = (pos + 1) % 8;
    end
    started = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    logic [7:0] exp_uio;
    if (started) begin
      exp_uio = {4'b0000, pos[0], m_err, m_bvld, m_avld};
      n_cmp++;
      if (uo_out !== m_out) begin
        n_bad++;
        $display("FAIL cyc_uo_out t=%0t actual=%h required=%h", $time, uo_out, m_out);
      end
      n_cmp++;
      if (uio_out !== exp_uio) begin
        n_bad++;
        $display("FAIL cyc_uio_out t=%0t actual=%b required=%b", $time, uio_out, exp_uio);
      end
      n_cmp++;
      if (uio_oe !== 8'h0F) begin
        n_bad++;
        $display("FAIL cyc_uio_oe t=%0t actual=%h required=0f", $time, uio_oe);
      end
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs; returns 2 time units after the sampling edge.
  task automatic step(input logic v, input logic fs, input logic d);
    ui_in = {5'b10101, v, fs, d};
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) step(1'b1, 1'b1, 1'b1);
    rst_n = 1'b1;
  endtask

  // Send a full frame for nibbles a/b; gap inserts a V=0 cycle (with FS noise) after each sample.
  task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input bit gap);
    for (int i = 0; i < 8; i++) begin
      logic bitv;
      bitv = (i % 2 == 0) ? a[3 - i/2] : b[3 - i/2];
      step(1'b1, (i == 0), bitv);
      if (gap) step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    logic [7:0] pat;
    n_cmp  = 0;
    n_bad  = 0;
    ena    = 1'b1;
    uio_in = 8'h5A;
    rst_n  = 1'b0;
    ui_in  = 8'h00;

    do_reset(2);
    chk("reset_uo_out", uo_out, 8'h00);
    chk("reset_uio_out", uio_out, 8'h00);
    chk("reset_uio_oe", uio_oe, 8'h0F);

    // D = 1,0,0,1,1,0,0,1 -> A=A, B=5
    pat = 8'b1001_1001;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 0), pat[7 - i]);
      if (i == 6) begin
        chk("f1_a_vld", {7'd0, uio_out[0]}, 8'h01);
        chk("f1_a_nib", {4'd0, uo_out[3:0]}, 8'h0A);
      end
    end
    chk("f1_b_vld", {7'd0, uio_out[1]}, 8'h01);
    chk("f1_out", uo_out, 8'h5A);
    chk("f1_err", {7'd0, uio_out[2]}, 8'h00);
    step(1'b0, 1'b0, 1'b0);
    chk("f1_vld_clear", {6'd0, uio_out[1:0]}, 8'h00);

    // Same frame with V toggling, after a reset so the nibbles are freshly built.
    do_reset(1);
    send_frame(4'hA, 4'h5, 1'b1);
    chk("f2_out", uo_out, 8'h5A);

    // Back-to-back frames with V held high.
    send_frame(4'h3, 4'hC, 1'b0);
    chk("f3_out", uo_out, 8'hC3);
    send_frame(4'hF, 4'h0, 1'b0);
    chk("f4_out", uo_out, 8'h0F);
    chk("f4_err", {7'd0, uio_out[2]}, 8'h00);

    // FS mid-frame on the 3rd sample; that sample starts a new frame A=6 B=9.
    step(1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("mis_err", {7'd0, uio_out[2]}, 8'h01);
    chk("mis_out_hold", uo_out, 8'h0F);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, (i % 2 == 0) ? 1'(4'h6 >> (3 - i/2)) : 1'(4'h9 >> (3 - i/2)));
    chk("mis_new_frame", uo_out, 8'h96);
    chk("mis_err_sticky", {7'd0, uio_out[2]}, 8'h01);

    // Reset after 5 samples of a frame, then a clean frame.
    for (int i = 0; i < 5; i++) step(1'b1, (i == 0), 1'b1);
    do_reset(1);
    send_frame(4'h6, 4'h9, 1'b0);
    chk("rst_abort_out", uo_out, 8'h96);
    chk("rst_abort_err", {7'd0, uio_out[2]}, 8'h00);

    // Random traffic: sparse FS, occasional reset.
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      step(1'($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
